// File: rtl/score_bcd_ctrl_if.sv
// rtl/score_bcd_ctrl_if.sv - load/score request and BCD display bundle for score_bcd_ctrl
interface score_bcd_ctrl_if;
   logic       load;
   logic [9:0] score;
   logic       busy;
   logic       done;
   logic [3:0] digit0;
   logic [3:0] digit1;
   logic [3:0] digit2;
   logic [3:0] digit3;
   logic [3:0] blank;

   modport master (
      output load, score,
      input  busy, done, digit0, digit1, digit2, digit3, blank
   );

   modport slave (
      input  load, score,
      output busy, done, digit0, digit1, digit2, digit3, blank
   );
endinterface

// File: rtl/score_bcd_ctrl.sv
// rtl/score_bcd_ctrl.sv - 10-bit score to 4-digit BCD via 10-step double dabble
// Optional leading-zero blanking under SCORE_LEADING_ZERO_BLANK_EN.
module score_bcd_ctrl (
   input logic             clk,
   input logic             resetn,
   score_bcd_ctrl_if.slave bus
);
   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_CONV = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]  r_state;
   logic [9:0]  r_shift;
   logic [15:0] r_bcd;
   logic [3:0]  r_cnt;
   logic        r_pend;
   logic [9:0]  r_pend_score;
   logic        r_done;
   logic [15:0] r_digit;

   logic [15:0] w_adj;
   logic [15:0] w_bcd_next;

   function automatic logic [3:0] adj3(input logic [3:0] n);
      return (n >= 4'd5) ? n + 4'd3 : n;
   endfunction

   always_comb begin
      w_adj      = {adj3(r_bcd[15:12]), adj3(r_bcd[11:8]), adj3(r_bcd[7:4]), adj3(r_bcd[3:0])};
      w_bcd_next = {w_adj[14:0], r_shift[9]};
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state      <= S_IDLE;
         r_shift      <= '0;
         r_bcd        <= '0;
         r_cnt        <= '0;
         r_pend       <= 1'b0;
         r_pend_score <= '0;
         r_done       <= 1'b0;
         r_digit      <= '0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (bus.load) begin
                  r_shift <= bus.score;
                  r_bcd   <= '0;
                  r_cnt   <= '0;
                  r_state <= S_CONV;
               end
            end
            S_CONV: begin
               if (bus.load) begin
                  r_pend       <= 1'b1;
                  r_pend_score <= bus.score;
               end
               r_bcd   <= w_bcd_next;
               r_shift <= {r_shift[8:0], 1'b0};
               r_cnt   <= r_cnt + 4'd1;
               if (r_cnt == 4'd9)
                  r_state <= S_DONE;
            end
            S_DONE: begin
               r_digit <= r_bcd;
               r_done  <= 1'b1;
               // A load arriving in this very cycle is the newest request and wins.
               if (bus.load || r_pend) begin
                  r_shift <= bus.load ? bus.score : r_pend_score;
                  r_bcd   <= '0;
                  r_cnt   <= '0;
                  r_pend  <= 1'b0;
                  r_state <= S_CONV;
               end else begin
                  r_state <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

`ifdef SCORE_LEADING_ZERO_BLANK_EN
   logic [3:0] r_blank;
   logic [3:0] w_blank;

   always_comb begin
      w_blank    = 4'b0000;
      w_blank[3] = (r_bcd[15:12] == 4'd0);
      w_blank[2] = w_blank[3] & (r_bcd[11:8] == 4'd0);
      w_blank[1] = w_blank[2] & (r_bcd[7:4] == 4'd0);
   end

   // Reset value matches a displayed 0000: only the ones digit stays lit.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn)
         r_blank <= 4'b1110;
      else if (r_state == S_DONE)
         r_blank <= w_blank;
   end

   assign bus.blank = r_blank;
`else
   assign bus.blank = 4'b0000;
`endif

   assign bus.busy   = (r_state != S_IDLE);
   assign bus.done   = r_done;
   assign bus.digit0 = r_digit[3:0];
   assign bus.digit1 = r_digit[7:4];
   assign bus.digit2 = r_digit[11:8];
   assign bus.digit3 = r_digit[15:12];
endmodule

// File: tb/tb_score_bcd_ctrl.sv
// tb/tb_score_bcd_ctrl.sv - scoreboard bench for score_bcd_ctrl against a decimal reference model
module tb_score_bcd_ctrl;
   logic clk;
   logic resetn;

   score_bcd_ctrl_if bus();

   score_bcd_ctrl dut (
      .clk    (clk),
      .resetn (resetn),
      .bus    (bus)
   );

   typedef struct {
      int cyc;
      int val;
   } exp_t;

   exp_t q[$];
   int   n_tests = 0;
   int   n_fail  = 0;
   int   cyc     = 0;
   int   disp    = 0;
   bit   m_busy  = 0;
   bit   m_pend  = 0;
   int   m_rem   = 0;
   int   m_cur   = 0;
   int   m_pv    = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
      end
   endtask

   function automatic int dig(input int v, input int i);
      int d;
      d = v;
      for (int k = 0; k < i; k++) d = d / 10;
      return (i == 3) ? d : d % 10;
   endfunction

   function automatic int exp_blank(input int v);
`ifdef SCORE_LEADING_ZERO_BLANK_EN
      if (v < 10)   return 4'b1110;
      if (v < 100)  return 4'b1100;
      if (v < 1000) return 4'b1000;
      return 0;
`else
      return (v < 0) ? 1 : 0;
`endif
   endfunction

   // Reference model: a request takes 11 edges; requests during a conversion
   // collapse to the latest one, which starts right as the current one finishes.
   initial begin
      forever begin
         @(posedge clk or negedge resetn);
         if (!resetn) begin
            m_busy = 0;
            m_pend = 0;
            m_rem  = 0;
            disp   = 0;
            q.delete();
         end else begin
            cyc++;
            if (m_busy) begin
               if (bus.load) begin
                  m_pend = 1;
                  m_pv   = int'(bus.score);
               end
               m_rem--;
               if (m_rem == 0) begin
                  q.push_back('{cyc, m_cur});
                  disp = m_cur;
                  if (m_pend) begin
                     m_cur  = m_pv;
                     m_rem  = 11;
                     m_pend = 0;
                  end else begin
                     m_busy = 0;
                  end
               end
            end else if (bus.load) begin
               m_busy = 1;
               m_cur  = int'(bus.score);
               m_rem  = 11;
            end
         end
      end
   end

   // Monitor: pops an expectation on every done pulse; display checked every cycle.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (bus.done) begin
            if (q.size() == 0) begin
               chk("done_unexpected", 1, 0);
            end else begin
               e = q.pop_front();
               chk("done_cycle", cyc, e.cyc);
               chk("done_d0", int'(bus.digit0), dig(e.val, 0));
               chk("done_d1", int'(bus.digit1), dig(e.val, 1));
               chk("done_d2", int'(bus.digit2), dig(e.val, 2));
               chk("done_d3", int'(bus.digit3), dig(e.val, 3));
               chk("done_blank", int'(bus.blank), exp_blank(e.val));
            end
         end
         while (q.size() > 0 && q[0].cyc < cyc) begin
            chk("done_missing", 0, 1);
            void'(q.pop_front());
         end
         chk("busy", int'(bus.busy), int'(m_busy));
         chk("digits", int'({bus.digit3, bus.digit2, bus.digit1, bus.digit0}),
             (dig(disp, 3) << 12) | (dig(disp, 2) << 8) | (dig(disp, 1) << 4) | dig(disp, 0));
         chk("blank", int'(bus.blank), exp_blank(disp));
      end
   end

   task automatic pulse_load(input int v);
      @(negedge clk);
      bus.load  = 1'b1;
      bus.score = 10'(v);
      @(negedge clk);
      bus.load  = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      int pick;
      int edge_vals[8];
      edge_vals = '{0, 1023, 9, 10, 99, 100, 999, 1000};
      resetn    = 1'b0;
      bus.load  = 1'b0;
      bus.score = '0;
      idle(3);
      resetn = 1'b1;
      idle(2);

      pulse_load(0);    idle(13);
      pulse_load(1023); idle(13);
      pulse_load(42);   idle(13);
      pulse_load(999);  idle(13);

      pulse_load(500);
      idle(3);
      pulse_load(7);
      idle(2);
      pulse_load(8);
      idle(28);

      pulse_load(42);   idle(13);
      pulse_load(1023);
      repeat (5) @(posedge clk);
      #2 resetn = 1'b0;
      repeat (2) @(posedge clk);
      #2 resetn = 1'b1;
      bus.load  = 1'b1;
      bus.score = 10'd1;
      @(negedge clk);
      bus.load = 1'b0;
      idle(13);

      // Load landing exactly on the DONE cycle chains straight into a new conversion.
      pulse_load(300);
      idle(9);
      pulse_load(77);
      idle(14);

      for (int i = 0; i < 600; i++) begin
         @(negedge clk);
         bus.load = ($urandom_range(0, 7) == 0);
         pick = int'($urandom_range(0, 3));
         bus.score = (pick == 0) ? 10'(edge_vals[$urandom_range(0, 7)]) : 10'($urandom_range(0, 1023));
      end
      @(negedge clk);
      bus.load = 1'b0;
      idle(30);

      chk("queue_empty", q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/score_bcd_ctrl.md
SCORE_BCD_CTRL -- requirements
Module: score_bcd_ctrl

Interface
REQ-001 The block SHALL have the port `clk`, input, 1 bit: single system clock, all state updates on its rising edge.
REQ-002 The block SHALL have the port `resetn`, input, 1 bit: reset, asynchronous, active-low.
REQ-003 The block SHALL have the port `load`, input, 1 bit: request to convert `score`; sampled on the rising edge of `clk`.
REQ-004 The block SHALL have the port `score`, input, 10 bits: unsigned binary score, 0..1023.
REQ-005 The block SHALL have the port `busy`, output, 1 bit: high while a conversion is in progress.
REQ-006 The block SHALL have the port `done`, output, 1 bit: one-cycle pulse when new digits are presented.
REQ-007 The block SHALL have the ports `digit0`..`digit3`, outputs, 4 bits each: BCD ones/tens/hundreds/thousands, each feeding one seven-segment hex decoder.
REQ-008 The block SHALL have the port `blank`, output, 4 bits: bit i high means the display for digit i is to be blanked.

Function
REQ-009 The block SHALL implement the FSM states IDLE, CONV and DONE.
REQ-010 In IDLE with `load`=1 at edge k, the block SHALL capture `score` into the shift register, clear the BCD field and step counter, and enter CONV.
REQ-011 In CONV, each edge SHALL perform one double-dabble step: add 3 to each BCD nibble that is ≥5, then shift left one bit taking the next score MSB; 10 steps SHALL occur at edges k+1..k+10.
REQ-012 After the 10th step the block SHALL enter DONE; at edge k+11 it SHALL register `digit0`..`digit3` and `blank`, assert `done` for exactly one cycle, and return to IDLE.
REQ-013 `busy` SHALL be high from edge k through edge k+11 exclusive (11 cycles) and low in IDLE.
REQ-014 The digit outputs SHALL hold their last converted value until the next DONE; they SHALL never show intermediate values.
REQ-015 Each BCD nibble SHALL be ≤9 at all times; the thousands nibble SHALL be ≤1.
REQ-016 A `load` in CONV or DONE SHALL set a pending flag and store `score`; a later `load` while pending SHALL overwrite the stored value (latest wins).
REQ-017 When leaving DONE with pending set, the block SHALL go directly to CONV using the stored score and clear pending; `busy` SHALL stay high with no IDLE cycle.
REQ-018 `load` in the DONE cycle SHALL be treated as pending, per REQ-016.

Reset
REQ-019 On `resetn`=0 the block SHALL enter IDLE, with `busy`=0, `done`=0, pending=0, `digit0`..`digit3`=0 and `blank`=4'b0000 (or 4'b1110 with the REQ-021 macro), regardless of clock.
REQ-020 A reset during CONV SHALL abort the conversion without a `done` pulse; after release the block SHALL accept `load` on the first edge.

Configuration
REQ-021 With macro `SCORE_LEADING_ZERO_BLANK_EN` defined, the block SHALL compute `blank` with these rules:
- blank[3] = (digit3==0)
- blank[2] = blank[3] & (digit2==0)
- blank[1] = blank[2] & (digit1==0)
- blank[0] = 0 always
REQ-022 With `SCORE_LEADING_ZERO_BLANK_EN` undefined, `blank` SHALL be driven constant 4'b0000 and no blanking logic SHALL be synthesized.

Verification
REQ-023 Stimulus: load with score=0. Required response: done at k+11, digits 0/0/0/0, blank=1110 (macro) or 0000.
REQ-024 Stimulus: load with score=1023. Required response: digit3..0 = 1,0,2,3, blank=0000, busy high exactly 11 cycles.
REQ-025 Stimulus: load with score=42 (macro on). Required response: digit3..0 = 0,0,4,2, blank=1100; score=999 gives 0,9,9,9, blank=1000.
REQ-026 Stimulus: load 500, then load 7 and load 8 during CONV. Required response: first done shows 5,0,0 with busy held high, second done at +11 cycles shows 8, and 7 is never displayed.
REQ-027 Stimulus: load 1023 after a prior result of 42, then assert resetn=0 at step 5. Required response: no done pulse, digits 0, busy 0; after release, load 1 gives digit0=1 at k+11.
